// File: rtl/fp_madd_dot_seq.sv
// rtl/fp_madd_dot_seq.sv - single-precision dot-product sequencer around one fused multiply-add
// Optional build macro: FP_DOT_STICKY_FLAGS_EN (sticky overflow/underflow over the whole job)
module fp_madd_dot_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [2:0]       r_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             overflow,
    output logic             underflow,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [31:0]      acc;
    logic [LEN_W-1:0] count, len_q;
    logic [2:0]       rmode_q;
    logic             ovf_q, unf_q;
    logic [31:0]      madd_res;
    logic             madd_ovf, madd_unf;
    logic             accept;

    function automatic logic [5:0] lzc51(input logic [50:0] v);
        logic [5:0] n;
        n = 6'd51;
        for (int i = 0; i < 51; i++)
            if (v[i]) n = 6'(50 - i);
        return n;
    endfunction

    // Fused a*b+c with one rounding; returns {overflow, underflow, result}.
    // Every finite value is carried as a normalised 48-bit mantissa so the exact product survives alignment.
    function automatic logic [33:0] fp_madd(input logic [31:0] fp_a, input logic [31:0] fp_b,
                                            input logic [31:0] fp_c, input logic [2:0] rm);
        logic               sa, sb, sc, sp, s_big, s_res, neg, eff_sub, c_big;
        logic [7:0]         xa, xb, xc;
        logic [23:0]        ma, mb, mc, mant, mant_f;
        logic [47:0]        mp, mpn, c48, mcn, m_big, m_small;
        logic [5:0]         lz_p, lz_c, lz_s, dsh, shc;
        logic signed [11:0] ea, eb, ec, ep, ecn, e_big, e_small, diff, e_pre, sh_raw, e_res, e_fin;
        logic [49:0]        big50, small_j;
        logic [99:0]        small100;
        logic [50:0]        sum, mag, norm, n2;
        logic [101:0]       d102;
        logic [24:0]        mr;
        logic               g, st, inc, tiny, ovf, ovf_max;
        logic               any_nan, a_inf, b_inf, c_inf, a_zero, b_zero, inf_p, nan_res;
        logic [33:0]        res;

        {sa, xa} = fp_a[31:23];
        {sb, xb} = fp_b[31:23];
        {sc, xc} = fp_c[31:23];
        sp      = sa ^ sb;
        a_inf   = (xa == 8'hff) && (fp_a[22:0] == 23'h0);
        b_inf   = (xb == 8'hff) && (fp_b[22:0] == 23'h0);
        c_inf   = (xc == 8'hff) && (fp_c[22:0] == 23'h0);
        any_nan = ((xa == 8'hff) && (fp_a[22:0] != 23'h0)) ||
                  ((xb == 8'hff) && (fp_b[22:0] != 23'h0)) ||
                  ((xc == 8'hff) && (fp_c[22:0] != 23'h0));
        a_zero  = (fp_a[30:0] == 31'h0);
        b_zero  = (fp_b[30:0] == 31'h0);
        ma = {xa != 8'h00, fp_a[22:0]};
        mb = {xb != 8'h00, fp_b[22:0]};
        mc = {xc != 8'h00, fp_c[22:0]};
        ea = (xa == 8'h00) ? 12'sd1 : $signed({4'h0, xa});
        eb = (xb == 8'h00) ? 12'sd1 : $signed({4'h0, xb});
        ec = (xc == 8'h00) ? 12'sd1 : $signed({4'h0, xc});

        mp   = {24'h0, ma} * {24'h0, mb};
        lz_p = lzc51({mp, 3'b111});
        mpn  = mp << lz_p;
        ep   = (mp == 48'h0) ? -12'sd1000 : ea + eb - 12'sd300 - $signed({6'h0, lz_p});
        c48  = {mc, 24'h0};
        lz_c = lzc51({c48, 3'b111});
        mcn  = c48 << lz_c;
        ecn  = (mc == 24'h0) ? -12'sd1000 : ec - 12'sd174 - $signed({6'h0, lz_c});

        c_big   = ecn > ep;
        e_big   = c_big ? ecn : ep;
        e_small = c_big ? ep : ecn;
        m_big   = c_big ? mcn : mpn;
        m_small = c_big ? mpn : mcn;
        s_big   = c_big ? sc : sp;
        diff    = e_big - e_small;
        dsh     = (diff > 12'sd50) ? 6'd50 : diff[5:0];
        big50   = {m_big, 2'b00};
        small100 = {m_small, 52'h0} >> dsh;
        // Shifted-out bits are jammed into the LSB, far below the rounding position.
        small_j = small100[99:50] | {49'h0, |small100[49:0]};
        eff_sub = sp ^ sc;
        sum     = eff_sub ? {1'b0, big50} - {1'b0, small_j} : {1'b0, big50} + {1'b0, small_j};
        neg     = eff_sub & sum[50];
        mag     = neg ? 51'h0 - sum : sum;
        s_res   = s_big ^ neg;

        lz_s   = lzc51(mag);
        norm   = mag << lz_s;
        e_pre  = e_big - $signed({6'h0, lz_s}) + 12'sd175;
        tiny   = e_pre < 12'sd1;
        sh_raw = 12'sd1 - e_pre;
        shc    = !tiny ? 6'd0 : (sh_raw > 12'sd51) ? 6'd51 : sh_raw[5:0];
        d102   = {norm, 51'h0} >> shc;
        n2     = d102[101:51];
        e_res  = tiny ? 12'sd1 : e_pre;
        mant   = n2[50:27];
        g      = n2[26];
        st     = (|n2[25:0]) | (|d102[50:0]);
        case (rm)
            3'b001:  inc = 1'b0;
            3'b010:  inc = s_res & (g | st);
            3'b011:  inc = ~s_res & (g | st);
            3'b100:  inc = g;
            default: inc = g & (st | mant[0]);
        endcase
        mr      = {1'b0, mant} + {24'h0, inc};
        mant_f  = mr[24] ? mr[24:1] : mr[23:0];
        e_fin   = mr[24] ? e_res + 12'sd1 : e_res;
        ovf     = e_fin > 12'sd254;
        ovf_max = (rm == 3'b001) | ((rm == 3'b010) & ~s_res) | ((rm == 3'b011) & s_res);

        inf_p   = a_inf | b_inf;
        nan_res = any_nan | (a_inf & b_zero) | (a_zero & b_inf) | (inf_p & c_inf & (sp != sc));
        if (nan_res)
            res = {2'b00, 32'h7fc00000};
        else if (inf_p | c_inf)
            res = {2'b00, inf_p ? sp : sc, 8'hff, 23'h0};
        else if (mag == 51'h0)
            res = {2'b00, (sp == sc) ? sp : (rm == 3'b010), 31'h0};
        else if (ovf)
            res = {2'b10, ovf_max ? {s_res, 8'hfe, 23'h7fffff} : {s_res, 8'hff, 23'h0}};
        else
            res = {1'b0, tiny & (g | st), s_res, mant_f[23] ? e_fin[7:0] : 8'h00, mant_f[22:0]};
        return res;
    endfunction

    always_comb begin
        {madd_ovf, madd_unf, madd_res} = fp_madd(a, b, acc, rmode_q);
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = (len == '0) ? DONE : RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && count == LEN_W'(len_q - 1'b1)) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign result    = out_valid ? acc : 32'h0;
    assign overflow  = out_valid & ovf_q;
    assign underflow = out_valid & unf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= 32'h0;
            count   <= '0;
            len_q   <= '0;
            rmode_q <= 3'b000;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                len_q   <= len;
                rmode_q <= r_mode;
                acc     <= 32'h0;
                count   <= '0;
                ovf_q   <= 1'b0;
                unf_q   <= 1'b0;
            end else if (accept) begin
                acc   <= madd_res;
                count <= count + 1'b1;
`ifdef FP_DOT_STICKY_FLAGS_EN
                ovf_q <= ovf_q | madd_ovf;
                unf_q <= unf_q | madd_unf;
`else
                ovf_q <= madd_ovf;
                unf_q <= madd_unf;
`endif
            end
        end
    end

endmodule
